// File: rtl/seg_serial_drv.sv
// seg_serial_drv: builds an 8-bit-per-digit frame and shifts it MSB-first to a
// shift-register 7-segment display. It then pulses a latch.
// Latency: Done is high for the cycle after edge 16*DIGITS*CLK_DIV + CLK_DIV + 1 from the Start edge.
//   Pin outputs are registered from the FSM state, so they trail the state by one cycle.
// Backpressure: none. Start is accepted only in IDLE and is otherwise dropped, not queued.
// Ports:
//   clk, rst_n (sync, active-low)
//   Start, Text_mode, Disp_num, Point_in, LE: frame request and content
//   seg_clk, seg_sout, seg_latch, seg_clrn: board pins
//   Busy, Done: status back to the requester
module seg_serial_drv #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Start,
  input  logic                Text_mode,
  input  logic [8*DIGITS-1:0] Disp_num,
  input  logic [DIGITS-1:0]   Point_in,
  input  logic [DIGITS-1:0]   LE,
  output logic                seg_clk,
  output logic                seg_sout,
  output logic                seg_latch,
  output logic                seg_clrn,
  output logic                Busy,
  output logic                Done
);

  localparam int NBITS = 8 * DIGITS;
  localparam int BCW   = $clog2(NBITS + 1);
  localparam int DCW   = $clog2(CLK_DIV + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);
  localparam logic [DCW-1:0] LAST_DIV = DCW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] frame_new;
  logic [NBITS-1:0] frame_q;
  logic [7:0]       txt_byte;
  logic [BCW-1:0]   bit_cnt;
  logic [DCW-1:0]   div_cnt;
  logic             load;
  logic             div_last;
  logic             bit_last;
  logic             timed_state;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_seg = 7'h3F;
      4'h1:    hex_seg = 7'h06;
      4'h2:    hex_seg = 7'h5B;
      4'h3:    hex_seg = 7'h4F;
      4'h4:    hex_seg = 7'h66;
      4'h5:    hex_seg = 7'h6D;
      4'h6:    hex_seg = 7'h7D;
      4'h7:    hex_seg = 7'h07;
      4'h8:    hex_seg = 7'h7F;
      4'h9:    hex_seg = 7'h6F;
      4'hA:    hex_seg = 7'h77;
      4'hB:    hex_seg = 7'h7C;
      4'hC:    hex_seg = 7'h39;
      4'hD:    hex_seg = 7'h5E;
      4'hE:    hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

  // Digit i lands in frame bits [8i+7:8i]. The frame is shifted MSB-first,
  // so the highest digit goes out first.
  always_comb begin
    frame_new = '0;
    txt_byte  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (LE[i]) txt_byte = 8'h00;
      else       txt_byte = {Point_in[i], hex_seg(Disp_num[4*i +: 4])};
      if (SEG_ACTIVE_LOW) txt_byte = ~txt_byte;
      frame_new[8*i +: 8] = Text_mode ? txt_byte : Disp_num[8*i +: 8];
    end
  end

  assign div_last    = (div_cnt == LAST_DIV);
  assign bit_last    = (bit_cnt == LAST_BIT);
  assign timed_state = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = SHIFT_LO;
          load      = 1'b1;
        end
      end
      SHIFT_LO: if (div_last) state_nxt = SHIFT_HI;
      SHIFT_HI: if (div_last) state_nxt = bit_last ? LATCH : SHIFT_LO;
      LATCH:    if (div_last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_q   <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_latch <= 1'b0;
      seg_clrn  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      seg_clrn <= 1'b1;

      // Every timed phase ends exactly when div_cnt hits LAST_DIV, so the
      // counter simply wraps to zero there.
      if (timed_state && !div_last) div_cnt <= div_cnt + 1'b1;
      else                          div_cnt <= '0;

      if (load) begin
        frame_q <= frame_new;
        bit_cnt <= '0;
      end else if (state == SHIFT_HI && div_last) begin
        frame_q <= frame_q << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end

      // seg_sout samples frame_q before the shift at the end of SHIFT_HI.
      // Data therefore changes only when seg_clk falls.
      seg_clk   <= (state == SHIFT_HI);
      seg_sout  <= (state == SHIFT_LO || state == SHIFT_HI) ? frame_q[NBITS-1] : 1'b0;
      seg_latch <= (state == LATCH);
      Busy      <= timed_state;
      Done      <= (state == DONE);
    end
  end

endmodule

// File: doc/seg_serial_drv.md
Name: seg_serial_drv

Overview:
- Parametrised serial driver for the board's shift-register 7-segment display; successor to the combinational segment-bit mapper.
- Builds a frame of 8 bits per digit in one of two modes: hex text decode, or raw graphic bytes.
- Shifts the frame out MSB-first on a divided serial clock, then pulses a latch.
- Sits between the display-data mux and the board pins; the CPU/debug logic requests a refresh with a one-cycle Start.

Parameters:
- DIGITS, 8: number of 7-segment digits (1..16).
- CLK_DIV, 2: clk cycles per half-period of seg_clk (>=1).
- SEG_ACTIVE_LOW, 1: 1 = text-mode segment bits are inverted (1 = off).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- Start  in  1  refresh request; sampled only in IDLE.
- Text_mode  in  1  1 = hex decode, 0 = graphic raw bytes.
- Disp_num  in  8*DIGITS  text mode: bits [4*DIGITS-1:0] are nibbles, digit i = [4i+3:4i]; graphic mode: digit i byte = [8i+7:8i].
- Point_in  in  DIGITS  decimal-point enable per digit (text mode only).
- LE  in  DIGITS  blank per digit (text mode only); 1 = all segments and dp off.
- seg_clk  out  1  serial shift clock to the board.
- seg_sout  out  1  serial data, valid across the seg_clk rising edge.
- seg_latch  out  1  output-latch pulse after the last bit.
- seg_clrn  out  1  clear to the external register, active-low.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values (rst_n=0 at a clk edge):
  - State = IDLE.
  - seg_clk=0, seg_sout=0, seg_latch=0, Busy=0, Done=0.
  - seg_clrn=0; it goes to 1 on the first edge with rst_n=1.
- Byte format (active-high form): {dp,g,f,e,d,c,b,a}.
  - Hex table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - dp = Point_in[i].
  - LE[i]=1 forces 00.
  - If SEG_ACTIVE_LOW=1, the final text byte is inverted.
  - Graphic-mode bytes pass unchanged; Point_in and LE are ignored.
- Frame order: digit DIGITS-1 first, bit 7 first within each byte; 8*DIGITS bits total.
- States: IDLE -> SHIFT_LO -> SHIFT_HI -> (next bit: SHIFT_LO | last: LATCH) -> DONE -> IDLE.
- IDLE:
  - On an edge with Start=1, the frame is built from the current inputs and captured into a shift register; Text_mode is captured too.
  - Bit counter and divide counter are cleared; Busy=1; next state is SHIFT_LO.
- SHIFT_LO: CLK_DIV cycles, seg_clk=0, seg_sout = current frame MSB.
- SHIFT_HI: CLK_DIV cycles, seg_clk=1, seg_sout held. On exit the frame shifts left by 1 and the bit counter increments.
- LATCH: entered after bit 8*DIGITS-1; lasts CLK_DIV cycles with seg_latch=1, seg_clk=0.
- DONE: one cycle with Done=1 and Busy=0, then IDLE.
- Latency: with Start sampled at edge 0, Done is high for the cycle following edge 16*DIGITS*CLK_DIV + CLK_DIV + 1 (259 with defaults).
- Start is ignored in every state except IDLE, including DONE; it is not queued.
- Input changes after capture do not affect the frame in progress.
- rst_n=0 mid-frame aborts the frame at that edge: all reset values apply, with no latch and no Done pulse.
- Counter widths: bit counter ceil(log2(8*DIGITS+1)), divide counter ceil(log2(CLK_DIV+1)); no wrap is permitted within a frame.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0, seg_clrn=0. Release -> seg_clrn=1 one edge later; Busy stays 0 with no Start.
- Text frame (defaults): Disp_num[31:0]=0x01234567, Point_in=0, LE=0, Text_mode=1, Start pulse.
  - Bytes sampled on seg_clk rises = C0 F9 A4 B0 99 92 82 F8.
  - One seg_latch pulse of 2 cycles; Done at edge 259.
- Point/blank: Disp_num[31:0]=0x88888888, Point_in=0x01, LE=0x80 -> first byte FF, digits 6..1 byte 80, last byte 00.
- Graphic mode: Text_mode=0, Disp_num=0xA55A0FF0_12345678, Point_in=0xFF, LE=0xFF -> bytes A5 5A 0F F0 12 34 56 78, unmodified.
- Busy interlock: second Start at bit 10 and Disp_num changed mid-frame -> shifted bytes still equal the captured frame; exactly one Done; a new Start after Done produces a new frame.
- Abort: rst_n=0 during bit 20 -> on the next edge seg_clk=0, Busy=0, seg_clrn=0; no seg_latch and no Done observed.
